fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Generates the 2-bit select for the EX-stage ALU operand 3:1 muxes (A and B) and the
//  load-use stall for the 5-stage MIPS pipeline. Keeps its own shadow copy of the
//  destination/control fields for the EX, EX/MEM and MEM/WB stages. Sits between decode
//  and the EX-stage operand muxes. Sel encoding: 00 regfile value, 01 EX/MEM ALU result,
//  10 MEM/WB writeback value.
// PARAMETERS
//  REG_ADDR_W  5   register address width
//  CNT_W       32  width of the stall performance counter
// PORTS
//  clk           in   1           clock, all state updates on rising edge
//  rst           in   1           synchronous, active-high reset
//  id_valid      in   1           ID-stage holds a real instruction
//  id_rs         in   REG_ADDR_W  ID source register 1
//  id_rt         in   REG_ADDR_W  ID source register 2
//  id_uses_rt    in   1           ID instruction reads rt as an operand
//  id_rd         in   REG_ADDR_W  ID destination register (already rd/rt resolved)
//  id_reg_write  in   1           ID instruction writes the register file
//  id_mem_read   in   1           ID instruction is a load
//  flush         in   1           branch/jump taken: kill the ID instruction
//  fwd_a_sel     out  2           operand-A mux select for the EX instruction
//  fwd_b_sel     out  2           operand-B mux select for the EX instruction
//  stall         out  1           hold PC and IF/ID, insert bubble into EX
//  stall_count   out  CNT_W       number of stall cycles since reset, saturating
// BEHAVIOUR
//  - Shadow stages ex, mem, wb; each holds {valid, rs, rt, uses_rt, rd, reg_write, mem_read}.
//  - Each edge (rst=0): wb<=mem; mem<=ex; ex<=bubble if (stall|flush|!id_valid), else ID fields.
//    Bubble = all fields 0 (valid, reg_write, mem_read cleared).
//  - rst=1 at an edge: all shadow fields 0, stall_count 0. Outputs after reset:
//    fwd_a_sel=00, fwd_b_sel=00, stall=0, stall_count=0. Reset mid-operation discards all
//    in-flight entries; no forwarding is produced from pre-reset instructions.
//  - fwd_a_sel (combinational from registered state, valid same cycle the EX instr is present):
//    01 if mem.reg_write & !mem.mem_read & mem.rd!=0 & mem.rd==ex.rs;
//    else 10 if wb.reg_write & wb.rd!=0 & wb.rd==ex.rs; else 00.
//  - fwd_b_sel: same rule against ex.rt, additionally gated by ex.uses_rt (else 00).
//  - EX/MEM has priority over MEM/WB (newest producer wins). Sel value 11 is never driven.
//  - Register 0 is never forwarded; writes to r0 never match.
//  - stall = !flush & id_valid & ex.mem_read & ex.rd!=0 &
//    (ex.rd==id_rs | (id_uses_rt & ex.rd==id_rt)). Combinational; asserts exactly one cycle
//    per load-use pair since the next EX entry is a bubble. Load then reaches MEM/WB when
//    the consumer enters EX, so the consumer receives sel 10.
//  - flush and stall condition in same cycle: flush wins, stall=0, bubble into EX.
//  - stall_count increments by 1 on every edge where stall=1; holds at 2^CNT_W-1.
//  - Latency: 0 cycles from state to outputs; state advances 1 stage per clock.
// TESTING
//  1 r-type rd=3 then r-type rs=3 back-to-back -> consumer in EX: fwd_a_sel=01, stall=0.
//  2 rd=3 producer, independent instr, consumer rt=3 uses_rt=1 -> fwd_b_sel=10; producers
//    rd=4 at both distances, consumer rs=4 -> fwd_a_sel=01 (priority).
//  3 lw rd=5 then add rs=5 -> stall=1 for exactly 1 cycle, stall_count 0->1, then consumer
//    in EX with fwd_a_sel=10.
//  4 producer rd=0 reg_write=1, consumer rs=0,rt=0 -> both sels 00; lw rd=0 -> no stall.
//  5 lw rd=7 in EX, ID rs=7 with flush=1 -> stall=0, next EX entry is bubble, count unchanged.
//  6 rst=1 while producers in EX/MEM and MEM/WB -> next cycle all sels 00, stall 0, count 0;
//    uses_rt=0 with rt match -> fwd_b_sel=00.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle for the forwarding/hazard unit: ID-stage instruction fields in,
// operand-mux selects, load-use stall and stall counter out.
//
// Qualification: id_valid marks the ID fields as a real instruction in the current cycle.
// There is no backpressure handshake; the unit answers combinationally in the same cycle.
// When stall is high, decode must hold the same instruction on the ID fields for the next
// cycle. flush kills whatever is on the ID fields in that cycle.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    // Decode / pipeline control side.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count
    );

    // Forwarding / hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage MIPS pipeline.
// Tracks shadow copies of the EX, EX/MEM and MEM/WB destination/control fields and
// produces the EX operand-mux selects (00 regfile, 01 EX/MEM ALU, 10 MEM/WB writeback),
// the one-cycle load-use stall and a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic                clk,
    input logic                rst,
    fwd_hazard_unit_if.slave   bus
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // EX keeps the full record; the later stages only keep the fields the
    // forwarding compares read (source fields are dead once past EX).
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wb_stage_t;

    ex_stage_t        ex_q;
    mem_stage_t       mem_q;
    wb_stage_t        wb_q;
    ex_stage_t        ex_next;
    logic [CNT_W-1:0] stall_count_q;
    logic             stall_c;
    logic [1:0]       a_sel_c;
    logic [1:0]       b_sel_c;

    // Newest producer wins: an EX/MEM ALU result beats the MEM/WB value. A load in
    // EX/MEM has no data yet, so it never forwards from there. r0 never matches.
    function automatic logic [1:0] pick_src(
        input logic [REG_ADDR_W-1:0] src,
        input mem_stage_t            m,
        input wb_stage_t             w
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (m.valid && m.reg_write && !m.mem_read && (m.rd != '0) && (m.rd == src)) begin
            sel = SEL_MEM;
        end else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Load-use detection: the load in EX cannot serve the ID instruction next cycle.
    // A flushed ID instruction is being discarded anyway, so it never stalls.
    always_comb begin
        stall_c = 1'b0;
        if (!bus.flush && bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)) begin
            stall_c = (ex_q.rd == bus.id_rs) || (bus.id_uses_rt && (ex_q.rd == bus.id_rt));
        end
    end

    // Operand-mux selects for the instruction currently in EX.
    always_comb begin
        a_sel_c = pick_src(ex_q.rs, mem_q, wb_q);
        b_sel_c = SEL_RF;
        if (ex_q.uses_rt) begin
            b_sel_c = pick_src(ex_q.rt, mem_q, wb_q);
        end
    end

    // Next EX entry: the ID instruction, or an all-zero bubble when stalled, flushed or empty.
    always_comb begin
        ex_next = '0;
        if (!stall_c && !bus.flush && bus.id_valid) begin
            ex_next.valid     = 1'b1;
            ex_next.rs        = bus.id_rs;
            ex_next.rt        = bus.id_rt;
            ex_next.uses_rt   = bus.id_uses_rt;
            ex_next.rd        = bus.id_rd;
            ex_next.reg_write = bus.id_reg_write;
            ex_next.mem_read  = bus.id_mem_read;
        end
    end

    // Advance the shadow pipeline one stage and count stall cycles (saturating).
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            wb_q.valid      <= mem_q.valid;
            wb_q.rd         <= mem_q.rd;
            wb_q.reg_write  <= mem_q.reg_write;
            mem_q.valid     <= ex_q.valid;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_read  <= ex_q.mem_read;
            ex_q            <= ex_next;
            if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign bus.fwd_a_sel   = a_sel_c;
    assign bus.fwd_b_sel   = b_sel_c;
    assign bus.stall       = stall_c;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed cycle table for the scenario corner cases, then
// randomized traffic checked against an instruction-age reference model.
module tb_fwd_hazard_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fwd_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: ID inputs, then outputs expected before the edge.
    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ut;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        fl;
        logic        chk;
        logic [1:0]  ea;
        logic [1:0]  eb;
        logic        es;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic r, input logic v, input int rs, input int rt,
                                 input logic ut, input int rd, input logic rw, input logic mr,
                                 input logic fl, input logic chk, input int ea, input int eb,
                                 input logic es, input int ec);
        vec_t x;
        x.rst = r;  x.v = v;  x.rs = 5'(rs); x.rt = 5'(rt); x.ut = ut; x.rd = 5'(rd);
        x.rw = rw;  x.mr = mr; x.fl = fl; x.chk = chk;
        x.ea = 2'(ea); x.eb = 2'(eb); x.es = es; x.ec = 32'(ec);
        return x;
    endfunction

    function automatic vec_t idle(input int ea, input int eb, input int ec);
        return row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ea, eb, 0, ec);
    endfunction

    // Driver tasks
    task automatic drive(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ut, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic fl);
        rst              = r;
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rt   = ut;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Reference model: the last three instructions to enter EX, by age.
    // age[0] is in EX now, age[1] is one stage ahead, age[2] two stages ahead.
    typedef struct {
        bit valid;
        int rs;
        int rt;
        bit ut;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t    age[3];
    longint  m_cnt;
    ins_t    empty_ins;

    // Where the EX instruction should take register r from.
    function automatic int src_for(input int r, input bit used);
        if (!used || r == 0) return 0;
        if (age[1].valid && age[1].rw && !age[1].mr && age[1].rd == r) return 1;
        if (age[2].valid && age[2].rw && age[2].rd == r) return 2;
        return 0;
    endfunction

    function automatic bit model_stall(input bit v, input int rs, input int rt, input bit ut,
                                       input bit fl);
        if (fl || !v) return 0;
        if (!(age[0].valid && age[0].mr) || age[0].rd == 0) return 0;
        return (age[0].rd == rs) || (ut && age[0].rd == rt);
    endfunction

    function automatic void model_clock(input bit r, input bit s, input ins_t id, input bit fl);
        if (r) begin
            for (int k = 0; k < 3; k++) age[k] = empty_ins;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            age[2] = age[1];
            age[1] = age[0];
            age[0] = (s || fl || !id.valid) ? empty_ins : id;
        end
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        empty_ins = '{default: 0};
        for (int k = 0; k < 3; k++) age[k] = empty_ins;
        m_cnt = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- directed table ----------------
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // back-to-back r-type: EX/MEM forward on A
        tbl.push_back(row(0, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 3, 2, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // distance-2 producer: MEM/WB forward on B
        tbl.push_back(row(0, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 9, 10, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 11, 3, 1, 12, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(0, 2, 0));
        tbl.push_back(idle(0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // two producers of r4: newest wins
        tbl.push_back(row(0, 1, 1, 2, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 2, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 4, 5, 1, 13, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // load-use: one stall cycle, then MEM/WB forward
        tbl.push_back(row(0, 1, 1, 5, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 5, 6, 1, 14, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 5, 6, 1, 14, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(idle(2, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        // r0 never forwards, lw r0 never stalls
        tbl.push_back(row(0, 1, 1, 2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, 0, 1, 15, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(row(0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, 0, 1, 16, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        // flush beats load-use stall; the killed instruction must not forward later
        tbl.push_back(row(0, 1, 1, 7, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 7, 1, 1, 9, 1, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 9, 0, 0, 16, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        // reset with producers in flight
        tbl.push_back(row(0, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, 2, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, 2, 1, 10, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 3, 4, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 3, 4, 1, 11, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // rt match but rt not an operand
        tbl.push_back(row(0, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 6, 0, 17, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].rd,
                  tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            if (tbl[i].chk) begin
                check("tbl_fwd_a", i, 32'(bus.fwd_a_sel), 32'(tbl[i].ea));
                check("tbl_fwd_b", i, 32'(bus.fwd_b_sel), 32'(tbl[i].eb));
                check("tbl_stall", i, 32'(bus.stall), 32'(tbl[i].es));
                check("tbl_count", i, bus.stall_count, tbl[i].ec);
            end
        end

        // ---------------- randomized vs reference model ----------------
        for (int c = 0; c < 800; c++) begin
            ins_t id;
            bit   r;
            bit   fl;
            bit   s;
            r           = (c == 0) || ($urandom_range(0, 63) == 0);
            fl          = ($urandom_range(0, 7) == 0);
            id.valid    = ($urandom_range(0, 3) != 0);
            id.rs       = $urandom_range(0, 3);
            id.rt       = $urandom_range(0, 3);
            id.ut       = $urandom_range(0, 1);
            id.rd       = $urandom_range(0, 3);
            id.rw       = ($urandom_range(0, 4) != 0);
            id.mr       = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            drive(r, id.valid, 5'(id.rs), 5'(id.rt), id.ut, 5'(id.rd), id.rw, id.mr, fl);
            #1;
            s = model_stall(id.valid, id.rs, id.rt, id.ut, fl);
            if (c != 0) begin
                check("rnd_fwd_a", c, 32'(bus.fwd_a_sel), 32'(src_for(age[0].rs, 1'b1)));
                check("rnd_fwd_b", c, 32'(bus.fwd_b_sel), 32'(src_for(age[0].rt, age[0].ut)));
                check("rnd_stall", c, 32'(bus.stall), 32'(s));
                check("rnd_count", c, bus.stall_count, 32'(m_cnt));
            end
            model_clock(r, s, id, fl);
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
